// File: rtl/mult_pkg.sv
// mult_pkg: definitions shared by the multiplier datapath blocks.
//   acc_state_t      - run-control states of the product accumulator
//   ACC_GUARD        - guard bits added above the 2N-bit product width
//   sat_pos/sat_neg  - most-positive / most-negative w-bit two's-complement
//                      values, returned zero-extended to SAT_MAX_W bits
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int unsigned ACC_GUARD = 8;
  localparam int unsigned SAT_MAX_W = 256;

  // 0111...1 in the low w bits
  function automatic logic [SAT_MAX_W-1:0] sat_pos(input int unsigned w);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i + 1 < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  // 1000...0 in the low w bits
  function automatic logic [SAT_MAX_W-1:0] sat_neg(input int unsigned w);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i + 1 == w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/acc_adder.sv
// acc_adder: combinational W-bit signed adder with overflow detection.
// Build option: PRODUCT_ACC_SAT_EN clamps the sum to the signed W-bit
// limits on overflow; otherwise the sum wraps modulo 2^W.
// Ports:
//   a, b  - signed operands
//   sum   - signed result (wrapped or clamped)
//   ovf   - operands share a sign and the raw result sign differs
module acc_adder
  import mult_pkg::*;
#(
  parameter int unsigned W = 72
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic [W-1:0] SAT_HI = W'(sat_pos(W));
  localparam logic [W-1:0] SAT_LO = W'(sat_neg(W));
`endif

  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef PRODUCT_ACC_SAT_EN
    if (ovf) begin
      // overflow direction follows the common operand sign
      sum = a[W-1] ? SAT_LO : SAT_HI;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of signed 2N-bit products
// into a guarded ACC_W-bit accumulator and presents one result per run.
// Build option: PRODUCT_ACC_SAT_EN selects saturating accumulation (see
// acc_adder); default is two's-complement wrap.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, len          - begin a run of len products (sampled in IDLE)
//   abort               - return to IDLE, dropping any beat/result
//   in_valid/in_ready   - product handshake, in_prod is the product
//   out_valid/out_ready - result handshake, out_acc is the sum
//   busy                - not in IDLE
//   overflow            - sticky per run, any addition left the ACC_W range
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned ACC_W = 2 * N + ACC_GUARD,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy,
  output logic             overflow
);

  acc_state_t       state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] prod_ext;
  logic [LEN_W-1:0] cnt;
  logic             ovf_sticky;
  logic             add_ovf;
  logic             load;
  logic             beat;

  assign prod_ext = ACC_W'($signed(in_prod));

  acc_adder #(
    .W (ACC_W)
  ) u_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          load     = 1'b1;
          state_nx = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        beat     = in_valid && !abort;
        if (beat && cnt == LEN_W'(1)) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // abort overrides start, beats and transfers in the same cycle
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      acc        <= '0;
      cnt        <= len;
      ovf_sticky <= 1'b0;
    end else if (beat) begin
      acc        <= acc_sum;
      cnt        <= cnt - 1'b1;
      ovf_sticky <= ovf_sticky | add_ovf;
    end
  end

  assign out_acc  = acc;
  assign overflow = ovf_sticky;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default N=32 instance plus an
// N=4, ACC_W=9 instance for the overflow / saturation vectors.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;

  // N=32 instance
  logic        a_start, a_abort, a_in_valid, a_out_ready;
  logic [15:0] a_len;
  logic [63:0] a_prod;
  logic        a_in_ready, a_out_valid, a_busy, a_overflow;
  logic [71:0] a_out_acc;

  // N=4, ACC_W=9 instance
  logic        b_start, b_abort, b_in_valid, b_out_ready;
  logic [15:0] b_len;
  logic [7:0]  b_prod;
  logic        b_in_ready, b_out_valid, b_busy, b_overflow;
  logic [8:0]  b_out_acc;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.N(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .len(a_len), .abort(a_abort),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_prod),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_acc(a_out_acc),
    .busy(a_busy), .overflow(a_overflow)
  );

  product_accumulator #(.N(4), .ACC_W(9), .LEN_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len), .abort(b_abort),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_prod),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc),
    .busy(b_busy), .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, out_valid, busy, overflow}
  function automatic logic [71:0] a_flags();
    return {68'd0, a_in_ready, a_out_valid, a_busy, a_overflow};
  endfunction

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_abort = 0; a_in_valid = 0; a_out_ready = 0; a_len = 0; a_prod = 0;
    b_start = 0; b_abort = 0; b_in_valid = 0; b_out_ready = 0; b_len = 0; b_prod = 0;
    #1;
    check("reset_flags", a_flags(), 72'b0000);
    check("reset_acc", a_out_acc, 72'd0);
    check("reset_flags_b", {68'd0, b_in_ready, b_out_valid, b_busy, b_overflow}, 72'd0);
    #12 rst_n = 1'b1;
    tick();

    // len=3, products 6, -4, 10 back-to-back
    a_start = 1; a_len = 3;
    tick();
    a_start = 0;
    check("len3_accum_flags", a_flags(), 72'b1010);
    a_in_valid = 1; a_prod = 64'(6);
    tick();
    a_prod = 64'(-4);
    tick();
    a_prod = 64'(10);
    tick();
    a_in_valid = 0;
    check("len3_hold_flags", a_flags(), 72'b0110);
    check("len3_sum", a_out_acc, 72'd12);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    check("len3_idle_flags", a_flags(), 72'b0000);

    // len=0: result next cycle, no in_ready
    a_start = 1; a_len = 0;
    tick();
    a_start = 0;
    check("len0_flags", a_flags(), 72'b0110);
    check("len0_sum", a_out_acc, 72'd0);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    check("len0_idle", a_flags(), 72'b0000);

    // len=2 with gaps and a stalled consumer
    a_start = 1; a_len = 2;
    tick();
    a_start = 0;
    tick();
    a_in_valid = 1; a_prod = 64'(100);
    tick();
    a_in_valid = 0;
    tick();
    tick();
    check("gap_still_accum", a_flags(), 72'b1010);
    check("gap_partial", a_out_acc, 72'd100);
    a_in_valid = 1; a_prod = 64'(-30);
    tick();
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_flags", a_flags(), 72'b0110);
      check("stall_sum", a_out_acc, 72'd70);
      tick();
    end
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    check("stall_release", a_flags(), 72'b0000);

    // N=4, ACC_W=9: five products of 64
    b_start = 1; b_len = 5;
    tick();
    b_start = 0;
    b_in_valid = 1; b_prod = 8'd64;
    for (int i = 0; i < 5; i++) tick();
    b_in_valid = 0;
    check("ovf_valid", {71'd0, b_out_valid}, 72'd1);
    check("ovf_flag", {71'd0, b_overflow}, 72'd1);
`ifdef PRODUCT_ACC_SAT_EN
    check("ovf_sum_sat", {63'd0, b_out_acc}, 72'h0FF);
`else
    check("ovf_sum_wrap", {63'd0, b_out_acc}, 72'h140);
`endif
    b_out_ready = 1;
    tick();
    b_out_ready = 0;
    // next start clears the sticky flag
    b_start = 1; b_len = 1;
    tick();
    b_start = 0;
    check("ovf_cleared", {70'd0, b_overflow, b_busy}, 72'b01);
    b_in_valid = 1; b_prod = 8'hFD;
    tick();
    b_in_valid = 0;
    check("small_neg_sum", {63'd0, b_out_acc}, 72'h1FD);
    b_out_ready = 1;
    tick();
    b_out_ready = 0;

    // abort on the third of four beats
    a_start = 1; a_len = 4;
    tick();
    a_start = 0;
    a_in_valid = 1; a_prod = 64'(5);
    tick();
    tick();
    a_prod = 64'(100); a_abort = 1;
    tick();
    a_abort = 0; a_in_valid = 0;
    check("abort_flags", a_flags(), 72'b0000);
    check("abort_acc_kept", a_out_acc, 72'd10);
    tick();
    check("abort_no_result", a_flags(), 72'b0000);
    // abort beats start in IDLE
    a_start = 1; a_abort = 1; a_len = 1;
    tick();
    a_abort = 0;
    check("abort_over_start", a_flags(), 72'b0000);
    tick();
    a_start = 0;
    check("restart_after_abort", a_flags(), 72'b1010);
    check("restart_cleared", a_out_acc, 72'd0);
    a_in_valid = 1; a_prod = 64'(3);
    tick();
    a_in_valid = 0;
    check("restart_sum", a_out_acc, 72'd3);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;

    // asynchronous reset mid-run
    a_start = 1; a_len = 3;
    tick();
    a_start = 0;
    a_in_valid = 1; a_prod = 64'(9);
    tick();
    a_in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flags", a_flags(), 72'b0000);
    check("async_rst_acc", a_out_acc, 72'd0);
    #1 rst_n = 1'b1;
    tick();
    a_start = 1; a_len = 1;
    tick();
    a_start = 0;
    a_in_valid = 1; a_prod = 64'(-7);
    tick();
    a_in_valid = 0;
    check("post_rst_flags", a_flags(), 72'b0110);
    check("post_rst_sum", a_out_acc, 72'(-7));
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    check("post_rst_idle", a_flags(), 72'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the signed array multiplier's 2N-bit product. It sums a programmed number of signed products into a guarded accumulator under a valid/ready handshake and presents one result per run. Together with the combinational multiplier it forms the dot-product / MAC datapath.

## Interface
- N, 32, multiplier operand width; products are 2N bits, two's complement.
- ACC_W, 2*N+8, accumulator width; must be at least 2N.
- LEN_W, 16, width of the run-length field.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- len  input  LEN_W  number of products in the run; sampled with start.
- abort  input  1  synchronous abort of the current run.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  the block accepts a product this cycle.
- in_prod  input  2N  signed product from the multiplier.
- out_valid  output  1  out_acc holds a finished result.
- out_ready  input  1  the consumer takes the result.
- out_acc  output  ACC_W  signed accumulated sum.
- busy  output  1  the block is not in IDLE.
- overflow  output  1  sticky per run; set when any addition exceeds the ACC_W signed range.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE
  - start with len>0: clear acc and overflow, load cnt=len, go to ACCUM.
  - start with len=0: clear acc and overflow, go to HOLD.
- ACCUM
  - in_ready=1.
  - On each beat (in_valid&&in_ready): acc += sign-extend(in_prod) to ACC_W, and cnt -= 1.
  - The beat with cnt==1 is the last one: go to HOLD.
- HOLD
  - out_valid=1. out_acc and overflow stay stable until out_valid&&out_ready.
  - After the transfer, go to IDLE.
- start is ignored outside IDLE.
- abort: from any state go to IDLE.
  - Drop any in-flight beat, do not produce a result, leave acc unchanged.
  - abort wins over start, a beat, or a transfer in the same cycle.
- Overflow: detected when both operands have the same sign and the result sign differs.
  - Default behaviour: the sum wraps modulo 2^ACC_W.
  - The overflow flag is set once and stays set until the next start.
- in_ready=0 in IDLE and HOLD.
- Reset values: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_acc=0, busy=0, overflow=0.
- Reset asserted mid-run discards the run immediately and asynchronously.

## Timing
- start accepted in cycle t: in_ready=1 from t+1.
- A beat accepted in cycle t is reflected in acc at t+1.
- Last beat accepted at t: out_valid=1 at t+1, with out_acc equal to the full sum.
- len=0 accepted at t: out_valid=1 at t+1, with out_acc=0.
- Result transferred at t: busy=0 at t+1; a new start is accepted from t+1.
- Throughput: one product per cycle. Minimum run period is len+2 cycles.
- in_valid gaps stall the run without limit; there is no timeout.

## Configuration
- PRODUCT_ACC_SAT_EN defined: on overflow, acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and stays clamped. The overflow flag behaves identically.
- PRODUCT_ACC_SAT_EN undefined: two's-complement wrap.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - the ACC_GUARD=8 constant;
  - the saturation-limit helper functions.
- One sub-module, acc_adder: combinational signed add with overflow detection and saturation under the macro. It is shared with future MAC variants.

## Test plan
- N=32: start, len=3, products 6, -4, 10 back-to-back → out_valid one cycle after the third beat, out_acc=12, overflow=0.
- start, len=0 → out_valid the next cycle, out_acc=0, no in_ready pulse.
- len=2 with in_valid gaps and out_ready held low for 5 cycles → out_acc stays stable, out_valid held, busy=1 until the transfer.
- N=4, ACC_W=9, len=5, every product 64:
  - without the macro: out_acc=-192, overflow=1;
  - with PRODUCT_ACC_SAT_EN: out_acc=255, overflow=1.
- abort after 2 of 4 beats, asserted together with in_valid → that beat is dropped, IDLE next cycle, no out_valid, and a new start is accepted.
- rst_n pulled low mid-ACCUM → all outputs at reset values immediately; the next run with len=1 and product -7 gives out_acc=-7.
